// File: rtl/sb_msg_arbiter_if.sv
// ============================================================================
// sb_msg_arbiter_if : request/SB bundle between handshake engines and arbiter
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface sb_msg_arbiter_if #(
    parameter int N_REQ        = 2,
    parameter int SB_MSG_WIDTH = 4
);
    logic [N_REQ-1:0]              i_req_valid;
    logic [N_REQ*SB_MSG_WIDTH-1:0] i_req_msg;
    logic                          i_SB_Busy;
    logic                          i_falling_edge_busy;
    logic                          i_flush;
    logic [SB_MSG_WIDTH-1:0]       o_encoded_SB_msg;
    logic                          o_tx_msg_valid;
    logic [N_REQ-1:0]              o_req_ack;
    logic [N_REQ-1:0]              o_grant;
    logic                          o_timeout;
    logic                          o_arb_busy;

    modport master (
        output i_req_valid, i_req_msg, i_SB_Busy, i_falling_edge_busy, i_flush,
        input  o_encoded_SB_msg, o_tx_msg_valid, o_req_ack, o_grant, o_timeout, o_arb_busy
    );

    modport slave (
        input  i_req_valid, i_req_msg, i_SB_Busy, i_falling_edge_busy, i_flush,
        output o_encoded_SB_msg, o_tx_msg_valid, o_req_ack, o_grant, o_timeout, o_arb_busy
    );
endinterface

`default_nettype wire

// File: rtl/sb_msg_arbiter.sv
// ============================================================================
// sb_msg_arbiter : shares one SB message-encode channel among N_REQ requesters
// Optional: SB_ARB_RR_EN selects round-robin instead of fixed priority.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sb_msg_arbiter #(
    parameter int N_REQ        = 2,
    parameter int SB_MSG_WIDTH = 4,
    parameter int TIMEOUT_CYC  = 255
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst_n,
    sb_msg_arbiter_if.slave sb
);
    localparam int c_CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam int c_IDX_W = $clog2(N_REQ);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = {c_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE        = 2'd0,
        S_LAUNCH      = 2'd1,
        S_WAIT_ACCEPT = 2'd2,
        S_ACK         = 2'd3
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [c_CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic [N_REQ-1:0]         r_mask, w_mask_nxt;
    logic [N_REQ-1:0]         r_grant, w_grant_nxt;
    logic [SB_MSG_WIDTH-1:0]  r_msg, w_msg_nxt;
    logic                     r_tx_valid, w_tx_valid_nxt;
    logic [N_REQ-1:0]         r_ack, w_ack_nxt;
    logic                     r_timeout, w_timeout_nxt;
    logic                     r_busy;

    logic [N_REQ-1:0]         w_cand;
    logic                     w_win_found;
    logic [c_IDX_W-1:0]       w_win_idx;

`ifdef SB_ARB_RR_EN
    logic [c_IDX_W-1:0]       r_ptr, w_ptr_nxt;
    logic [c_IDX_W-1:0]       r_own_idx, w_own_idx_nxt;
    int                       w_rr_idx;
`endif

    // Winner selection; the one-cycle mask keeps a just-acked requester out.
    always_comb begin
        w_cand      = sb.i_req_valid & ~r_mask;
        w_win_found = 1'b0;
        w_win_idx   = '0;
`ifdef SB_ARB_RR_EN
        w_rr_idx    = 0;
        for (int off = 0; off < N_REQ; off++) begin
            w_rr_idx = (int'(r_ptr) + off) % N_REQ;
            if (!w_win_found && w_cand[w_rr_idx]) begin
                w_win_found = 1'b1;
                w_win_idx   = c_IDX_W'(w_rr_idx);
            end
        end
`else
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_win_found = 1'b1;
                w_win_idx   = c_IDX_W'(i);
            end
        end
`endif
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_grant_nxt    = r_grant;
        w_msg_nxt      = r_msg;
        w_mask_nxt     = '0;
        w_tx_valid_nxt = 1'b0;
        w_ack_nxt      = '0;
        w_timeout_nxt  = 1'b0;
`ifdef SB_ARB_RR_EN
        w_ptr_nxt      = r_ptr;
        w_own_idx_nxt  = r_own_idx;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_win_found && !sb.i_SB_Busy) begin
                    w_state_nxt = S_LAUNCH;
                    w_grant_nxt = {{(N_REQ-1){1'b0}}, 1'b1} << w_win_idx;
                    w_msg_nxt   = sb.i_req_msg[int'(w_win_idx) * SB_MSG_WIDTH +: SB_MSG_WIDTH];
`ifdef SB_ARB_RR_EN
                    w_own_idx_nxt = w_win_idx;
`endif
                end
            end
            S_LAUNCH: begin
                w_tx_valid_nxt = 1'b1;
                w_state_nxt    = S_WAIT_ACCEPT;
                w_cnt_nxt      = '0;
            end
            S_WAIT_ACCEPT: begin
                // Edge beats timeout when both land in the same cycle.
                if (sb.i_falling_edge_busy) begin
                    w_state_nxt = S_ACK;
                    w_ack_nxt   = r_grant;
`ifdef SB_ARB_RR_EN
                    w_ptr_nxt   = (r_own_idx == c_IDX_W'(N_REQ - 1)) ? '0 : r_own_idx + 1'b1;
`endif
                end else if (r_cnt == c_CNT_LAST) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_nxt = 1'b1;
                    w_grant_nxt   = '0;
                    w_cnt_nxt     = '0;
                end else if (r_cnt != c_CNT_SAT) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_mask_nxt  = r_grant;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
            end
        endcase

        if (sb.i_flush) begin
            w_state_nxt    = S_IDLE;
            w_grant_nxt    = '0;
            w_mask_nxt     = '0;
            w_cnt_nxt      = '0;
            w_tx_valid_nxt = 1'b0;
            w_ack_nxt      = '0;
            w_timeout_nxt  = 1'b0;
            w_msg_nxt      = r_msg;
`ifdef SB_ARB_RR_EN
            w_ptr_nxt      = r_ptr;
            w_own_idx_nxt  = r_own_idx;
`endif
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_mask     <= '0;
            r_grant    <= '0;
            r_msg      <= '0;
            r_tx_valid <= 1'b0;
            r_ack      <= '0;
            r_timeout  <= 1'b0;
            r_busy     <= 1'b0;
`ifdef SB_ARB_RR_EN
            r_ptr      <= '0;
            r_own_idx  <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mask     <= w_mask_nxt;
            r_grant    <= w_grant_nxt;
            r_msg      <= w_msg_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_ack      <= w_ack_nxt;
            r_timeout  <= w_timeout_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
`ifdef SB_ARB_RR_EN
            r_ptr      <= w_ptr_nxt;
            r_own_idx  <= w_own_idx_nxt;
`endif
        end
    end

    assign sb.o_encoded_SB_msg = r_msg;
    assign sb.o_tx_msg_valid   = r_tx_valid;
    assign sb.o_req_ack        = r_ack;
    assign sb.o_grant          = r_grant;
    assign sb.o_timeout        = r_timeout;
    assign sb.o_arb_busy       = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_sb_msg_arbiter.sv
// ============================================================================
// tb_sb_msg_arbiter : directed self-checking bench for sb_msg_arbiter
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sb_msg_arbiter;
    localparam int N_REQ        = 2;
    localparam int SB_MSG_WIDTH = 4;
    localparam int TIMEOUT_CYC  = 8;

    logic i_clk   = 1'b0;
    logic i_rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    sb_msg_arbiter_if #(.N_REQ(N_REQ), .SB_MSG_WIDTH(SB_MSG_WIDTH)) bus ();

    sb_msg_arbiter #(
        .N_REQ       (N_REQ),
        .SB_MSG_WIDTH(SB_MSG_WIDTH),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .sb     (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({bus.o_encoded_SB_msg, bus.o_tx_msg_valid, bus.o_req_ack, bus.o_grant, bus.o_timeout, bus.o_arb_busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 000", {bus.o_encoded_SB_msg, bus.o_tx_msg_valid, bus.o_req_ack, bus.o_grant, bus.o_timeout, bus.o_arb_busy});
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        n_checks++;
        if (bus.o_arb_busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", bus.o_arb_busy); end
    endtask

    task automatic test_single();
        bus.i_req_msg   = 8'h05;
        bus.i_req_valid = 2'b01;
        step();
        n_checks++; if (bus.o_tx_msg_valid !== 1'b0) begin n_fail++; $display("FAIL single_launch_cycle_valid: got %b expected 0", bus.o_tx_msg_valid); end
        n_checks++; if (bus.o_grant !== 2'b01) begin n_fail++; $display("FAIL single_grant: got %b expected 01", bus.o_grant); end
        n_checks++; if (bus.o_arb_busy !== 1'b1) begin n_fail++; $display("FAIL single_arb_busy: got %b expected 1", bus.o_arb_busy); end
        step();
        n_checks++; if (bus.o_tx_msg_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", bus.o_tx_msg_valid); end
        n_checks++; if (bus.o_encoded_SB_msg !== 4'h5) begin n_fail++; $display("FAIL single_msg: got %h expected 5", bus.o_encoded_SB_msg); end
        step();
        n_checks++; if (bus.o_tx_msg_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_one_cycle: got %b expected 0", bus.o_tx_msg_valid); end
        repeat (4) step();
        n_checks++; if (bus.o_req_ack !== 2'b00) begin n_fail++; $display("FAIL single_no_early_ack: got %b expected 00", bus.o_req_ack); end
        bus.i_falling_edge_busy = 1'b1;
        step();
        bus.i_falling_edge_busy = 1'b0;
        n_checks++; if (bus.o_req_ack !== 2'b01) begin n_fail++; $display("FAIL single_ack: got %b expected 01", bus.o_req_ack); end
        n_checks++; if (bus.o_timeout !== 1'b0) begin n_fail++; $display("FAIL single_no_timeout: got %b expected 0", bus.o_timeout); end
        bus.i_req_valid = 2'b00;
        step();
        n_checks++; if (bus.o_req_ack !== 2'b00) begin n_fail++; $display("FAIL single_ack_one_cycle: got %b expected 00", bus.o_req_ack); end
        n_checks++; if (bus.o_grant !== 2'b00) begin n_fail++; $display("FAIL single_grant_idle: got %b expected 00", bus.o_grant); end
        n_checks++; if (bus.o_arb_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b expected 0", bus.o_arb_busy); end
        n_checks++; if (bus.o_encoded_SB_msg !== 4'h5) begin n_fail++; $display("FAIL single_msg_held: got %h expected 5", bus.o_encoded_SB_msg); end
        step();
    endtask

    task automatic test_contention();
        logic [1:0] g_first, g_second;
        logic [3:0] m_first, m_second;
`ifdef SB_ARB_RR_EN
        // Requester 0 was acked last, so the search starts at index 1.
        g_first = 2'b10; m_first = 4'hA; g_second = 2'b01; m_second = 4'h3;
`else
        g_first = 2'b01; m_first = 4'h3; g_second = 2'b10; m_second = 4'hA;
`endif
        bus.i_req_msg   = 8'hA3;
        bus.i_req_valid = 2'b11;
        step();
        n_checks++; if (bus.o_grant !== g_first) begin n_fail++; $display("FAIL contention_grant_first: got %b expected %b", bus.o_grant, g_first); end
        step();
        n_checks++; if ({bus.o_tx_msg_valid, bus.o_encoded_SB_msg} !== {1'b1, m_first}) begin n_fail++; $display("FAIL contention_msg_first: got %b/%h expected 1/%h", bus.o_tx_msg_valid, bus.o_encoded_SB_msg, m_first); end
        bus.i_falling_edge_busy = 1'b1;
        step();
        bus.i_falling_edge_busy = 1'b0;
        n_checks++; if (bus.o_req_ack !== g_first) begin n_fail++; $display("FAIL contention_ack_first: got %b expected %b", bus.o_req_ack, g_first); end
        step();
        n_checks++; if (bus.o_arb_busy !== 1'b0) begin n_fail++; $display("FAIL contention_idle_gap: got %b expected 0", bus.o_arb_busy); end
        step();
        n_checks++; if (bus.o_grant !== g_second) begin n_fail++; $display("FAIL contention_grant_second: got %b expected %b", bus.o_grant, g_second); end
        step();
        n_checks++; if ({bus.o_tx_msg_valid, bus.o_encoded_SB_msg} !== {1'b1, m_second}) begin n_fail++; $display("FAIL contention_msg_second: got %b/%h expected 1/%h", bus.o_tx_msg_valid, bus.o_encoded_SB_msg, m_second); end
        bus.i_falling_edge_busy = 1'b1;
        step();
        bus.i_falling_edge_busy = 1'b0;
        n_checks++; if (bus.o_req_ack !== g_second) begin n_fail++; $display("FAIL contention_ack_second: got %b expected %b", bus.o_req_ack, g_second); end
        bus.i_req_valid = 2'b00;
        step();
        step();
    endtask

    task automatic test_busy_gating();
        bus.i_SB_Busy   = 1'b1;
        bus.i_req_msg   = 8'hC0;
        bus.i_req_valid = 2'b10;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++;
            if ({bus.o_tx_msg_valid, bus.o_arb_busy} !== 2'b00) begin n_fail++; $display("FAIL busy_gated_cycle%0d: got %b expected 00", i, {bus.o_tx_msg_valid, bus.o_arb_busy}); end
        end
        bus.i_SB_Busy = 1'b0;
        step();
        n_checks++; if ({bus.o_tx_msg_valid, bus.o_grant} !== 3'b010) begin n_fail++; $display("FAIL busy_release_launch: got %b expected 010", {bus.o_tx_msg_valid, bus.o_grant}); end
        step();
        n_checks++; if ({bus.o_tx_msg_valid, bus.o_encoded_SB_msg} !== 5'h1C) begin n_fail++; $display("FAIL busy_release_valid: got %h expected 1c", {bus.o_tx_msg_valid, bus.o_encoded_SB_msg}); end
        // Requester drops its level mid-transaction; the ack must still come.
        bus.i_req_valid         = 2'b00;
        bus.i_falling_edge_busy = 1'b1;
        step();
        bus.i_falling_edge_busy = 1'b0;
        n_checks++; if (bus.o_req_ack !== 2'b10) begin n_fail++; $display("FAIL busy_dropped_req_ack: got %b expected 10", bus.o_req_ack); end
        step();
        step();
    endtask

    task automatic test_timeout();
        bus.i_req_msg   = 8'h06;
        bus.i_req_valid = 2'b01;
        step();
        step();
        n_checks++; if ({bus.o_tx_msg_valid, bus.o_encoded_SB_msg} !== 5'h16) begin n_fail++; $display("FAIL timeout_launch: got %h expected 16", {bus.o_tx_msg_valid, bus.o_encoded_SB_msg}); end
        for (int i = 0; i < 7; i++) begin
            step();
            n_checks++;
            if ({bus.o_timeout, bus.o_arb_busy} !== 2'b01) begin n_fail++; $display("FAIL timeout_early_cycle%0d: got %b expected 01", i, {bus.o_timeout, bus.o_arb_busy}); end
        end
        step();
        n_checks++; if (bus.o_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_pulse: got %b expected 1", bus.o_timeout); end
        n_checks++; if ({bus.o_req_ack, bus.o_grant, bus.o_arb_busy} !== 5'b00000) begin n_fail++; $display("FAIL timeout_abort_state: got %b expected 00000", {bus.o_req_ack, bus.o_grant, bus.o_arb_busy}); end
        step();
        n_checks++; if ({bus.o_timeout, bus.o_grant} !== 3'b001) begin n_fail++; $display("FAIL timeout_rearb: got %b expected 001", {bus.o_timeout, bus.o_grant}); end
        step();
        n_checks++; if (bus.o_tx_msg_valid !== 1'b1) begin n_fail++; $display("FAIL timeout_relaunch: got %b expected 1", bus.o_tx_msg_valid); end
        bus.i_falling_edge_busy = 1'b1;
        step();
        bus.i_falling_edge_busy = 1'b0;
        n_checks++; if (bus.o_req_ack !== 2'b01) begin n_fail++; $display("FAIL timeout_relaunch_ack: got %b expected 01", bus.o_req_ack); end
        bus.i_req_valid = 2'b00;
        step();
        step();
    endtask

    task automatic test_edge_timeout_collision();
        bus.i_req_msg   = 8'h0B;
        bus.i_req_valid = 2'b01;
        step();
        step();
        repeat (7) step();
        n_checks++; if ({bus.o_timeout, bus.o_arb_busy} !== 2'b01) begin n_fail++; $display("FAIL collision_pre: got %b expected 01", {bus.o_timeout, bus.o_arb_busy}); end
        bus.i_falling_edge_busy = 1'b1;
        step();
        bus.i_falling_edge_busy = 1'b0;
        n_checks++; if (bus.o_req_ack !== 2'b01) begin n_fail++; $display("FAIL collision_ack: got %b expected 01", bus.o_req_ack); end
        n_checks++; if (bus.o_timeout !== 1'b0) begin n_fail++; $display("FAIL collision_no_timeout: got %b expected 0", bus.o_timeout); end
        bus.i_req_valid = 2'b00;
        step();
        step();
    endtask

    task automatic test_flush();
        bus.i_req_msg   = 8'h09;
        bus.i_req_valid = 2'b01;
        step();
        step();
        n_checks++; if (bus.o_tx_msg_valid !== 1'b1) begin n_fail++; $display("FAIL flush_wait_launch: got %b expected 1", bus.o_tx_msg_valid); end
        bus.i_flush = 1'b1;
        step();
        bus.i_flush     = 1'b0;
        bus.i_req_valid = 2'b00;
        n_checks++; if ({bus.o_grant, bus.o_arb_busy, bus.o_req_ack} !== 5'b00000) begin n_fail++; $display("FAIL flush_wait_idle: got %b expected 00000", {bus.o_grant, bus.o_arb_busy, bus.o_req_ack}); end
        bus.i_falling_edge_busy = 1'b1;
        step();
        bus.i_falling_edge_busy = 1'b0;
        n_checks++; if ({bus.o_req_ack, bus.o_arb_busy} !== 3'b000) begin n_fail++; $display("FAIL flush_late_edge: got %b expected 000", {bus.o_req_ack, bus.o_arb_busy}); end

        bus.i_req_valid = 2'b01;
        step();
        n_checks++; if (bus.o_grant !== 2'b01) begin n_fail++; $display("FAIL flush_launch_grant: got %b expected 01", bus.o_grant); end
        bus.i_flush = 1'b1;
        step();
        n_checks++; if ({bus.o_tx_msg_valid, bus.o_grant, bus.o_arb_busy} !== 4'b0000) begin n_fail++; $display("FAIL flush_launch_suppress: got %b expected 0000", {bus.o_tx_msg_valid, bus.o_grant, bus.o_arb_busy}); end
        step();
        n_checks++; if ({bus.o_grant, bus.o_arb_busy} !== 3'b000) begin n_fail++; $display("FAIL flush_blocks_arb: got %b expected 000", {bus.o_grant, bus.o_arb_busy}); end
        bus.i_flush = 1'b0;
        step();
        n_checks++; if (bus.o_grant !== 2'b01) begin n_fail++; $display("FAIL flush_rearb_grant: got %b expected 01", bus.o_grant); end
        step();
        n_checks++; if (bus.o_tx_msg_valid !== 1'b1) begin n_fail++; $display("FAIL flush_rearb_valid: got %b expected 1", bus.o_tx_msg_valid); end
        bus.i_falling_edge_busy = 1'b1;
        step();
        bus.i_falling_edge_busy = 1'b0;
        n_checks++; if (bus.o_req_ack !== 2'b01) begin n_fail++; $display("FAIL flush_rearb_ack: got %b expected 01", bus.o_req_ack); end
        bus.i_req_valid = 2'b00;
        step();
        step();
    endtask

    task automatic test_async_reset();
        bus.i_req_msg   = 8'h07;
        bus.i_req_valid = 2'b01;
        step();
        step();
        n_checks++; if ({bus.o_tx_msg_valid, bus.o_encoded_SB_msg} !== 5'h17) begin n_fail++; $display("FAIL areset_pre_launch: got %h expected 17", {bus.o_tx_msg_valid, bus.o_encoded_SB_msg}); end
        #2;
        i_rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.o_encoded_SB_msg, bus.o_tx_msg_valid, bus.o_req_ack, bus.o_grant, bus.o_timeout, bus.o_arb_busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL areset_immediate: got %h expected 000", {bus.o_encoded_SB_msg, bus.o_tx_msg_valid, bus.o_req_ack, bus.o_grant, bus.o_timeout, bus.o_arb_busy});
        end
        bus.i_req_valid = 2'b00;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        n_checks++; if (bus.o_arb_busy !== 1'b0) begin n_fail++; $display("FAIL areset_release_idle: got %b expected 0", bus.o_arb_busy); end
    endtask

    initial begin
        bus.i_req_valid         = '0;
        bus.i_req_msg           = '0;
        bus.i_SB_Busy           = 1'b0;
        bus.i_falling_edge_busy = 1'b0;
        bus.i_flush             = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_busy_gating();
        test_timeout();
        test_edge_timeout_collision();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sb_msg_arbiter.md
Name: sb_msg_arbiter

Overview:
- Shares the single sideband (SB) message-encode channel between N_REQ handshake engines, e.g. the TX and RX halves of each LTSM state handshake.
- Captures one request at a time and launches it as a one-cycle valid pulse to the SB.
- Waits for SB acceptance (falling edge of busy), then acknowledges the owning requester.
- Adds an acceptance timeout and a synchronous flush so the LTSM can abort on a state change.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- SB_MSG_WIDTH, 4, width of one encoded SB message.
- TIMEOUT_CYC, 255, maximum cycles spent in WAIT_ACCEPT before abort (>=2).

Ports:
- i_clk  in  1  single clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  N_REQ  per-requester request level; held until acked, flushed or timed out.
- i_req_msg  in  N_REQ*SB_MSG_WIDTH  packed messages; requester k occupies bits [k*SB_MSG_WIDTH +: SB_MSG_WIDTH].
- i_SB_Busy  in  1  1 = SB cannot accept a new message.
- i_falling_edge_busy  in  1  one-cycle pulse: SB finished the current message.
- i_flush  in  1  synchronous abort of any transaction in flight.
- o_encoded_SB_msg  out  SB_MSG_WIDTH  message presented to SB.
- o_tx_msg_valid  out  1  one-cycle launch pulse.
- o_req_ack  out  N_REQ  one-hot, one-cycle acknowledge to the granted requester.
- o_grant  out  N_REQ  one-hot owner of the current transaction; 0 in IDLE.
- o_timeout  out  1  one-cycle pulse on acceptance timeout.
- o_arb_busy  out  1  1 whenever state != IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0, mask 0, RR pointer 0.
- All outputs are registered.
- States: IDLE, LAUNCH, WAIT_ACCEPT, ACK.
- IDLE -> LAUNCH:
  - Condition: (i_req_valid & ~mask) != 0 and i_SB_Busy == 0.
  - Select winner k; register o_grant = onehot(k); capture msg k into o_encoded_SB_msg.
  - If i_SB_Busy == 1, stay in IDLE and do not sample.
- LAUNCH:
  - o_tx_msg_valid = 1 for exactly this cycle.
  - Then unconditionally to WAIT_ACCEPT; clear the counter.
- WAIT_ACCEPT:
  - o_encoded_SB_msg is held stable.
  - i_falling_edge_busy = 1 -> ACK.
  - Otherwise counter += 1; when counter == TIMEOUT_CYC-1 with no edge, pulse o_timeout, return to IDLE with no ack, clear o_grant. The request remains pending and is re-arbitrated.
- ACK:
  - o_req_ack = o_grant for one cycle, then IDLE.
  - mask = o_grant for the first IDLE cycle only; this lets the requester drop its level without being re-granted. The mask clears after that cycle.
- Latency: request (SB idle) to o_tx_msg_valid = 2 cycles; falling edge to o_req_ack = 1 cycle.
- A falling edge arriving in the LAUNCH cycle is ignored; the edge must come in WAIT_ACCEPT.
- A falling edge and timeout in the same cycle: the edge wins, ACK is taken, no o_timeout.
- i_flush = 1 in any state:
  - Next state IDLE; o_grant, mask and counter cleared.
  - Any pending o_tx_msg_valid, o_req_ack and o_timeout are suppressed.
  - Flush has priority over every other transition.
  - Arbitration is blocked in the flush cycle.
- A requester dropping i_req_valid mid-transaction does not abort it; the ack is still issued.
- o_encoded_SB_msg is held at its last value in IDLE, so the SB ignores it while o_tx_msg_valid = 0.
- Counter width is $clog2(TIMEOUT_CYC+1) and it saturates; it never wraps.
- Arbitration is fixed priority by default: lowest index wins.

Optional Feature:
- Macro SB_ARB_RR_EN.
- Defined: round-robin arbitration. The search starts at index (ptr), where ptr = (last acked index + 1) mod N_REQ, updated only on ACK. Timeouts and flushes do not move ptr.
- Undefined: fixed priority, lowest index wins; ptr logic is absent.

Test Plan:
- Single request: req[0]=1, msg0=4'h5, SB idle.
  - o_tx_msg_valid pulses 2 cycles later with o_encoded_SB_msg=4'h5.
  - Falling edge 6 cycles later -> o_req_ack=2'b01 exactly one cycle after the edge.
- Contention: req=2'b11, msg0=4'h3, msg1=4'hA, both held.
  - Fixed priority: 4'h3 sent, ack0, then 4'hA sent, ack1.
  - With SB_ARB_RR_EN and ptr=1: 4'hA goes first.
- SB busy gating: i_SB_Busy=1 for 10 cycles with req[1]=1.
  - No o_tx_msg_valid while busy.
  - Launch 2 cycles after busy falls.
- Timeout: TIMEOUT_CYC=8, no falling edge after launch.
  - o_timeout pulses 8 cycles after WAIT_ACCEPT entry, no ack.
  - Request relaunches 2 cycles later.
- Flush/reset mid-transaction: assert i_flush in WAIT_ACCEPT.
  - Next cycle state IDLE, o_grant=0, no ack even if an edge arrives afterward.
  - Repeat with i_rst_n low asynchronously: all outputs 0 immediately.
- Edge vs timeout collision: falling edge in the cycle the counter reaches TIMEOUT_CYC-1.
  - o_req_ack asserted, o_timeout stays 0.
